// File: rtl/mult_acc_8x8_stage_pkg.sv
// Shared types and default widths for the multiply-accumulate stage that
// sits behind the 8x8 multiplier array.
package mult_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic [PROD_W_DEF-1:0] prod;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/mult_acc_8x8_stage_sat_add_acc.sv
// Combinational accumulator adder: one-bit-wider sum plus the clamp/wrap
// result chosen by SAT.
module sat_add_acc
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter bit SAT    = 1'b1
) (
    input  logic [ACC_W-1:0]  base,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W:0]    sum,
    output logic [ACC_W-1:0]  res
);

    // Add in ACC_W+1 bits so the carry out is the overflow flag.
    always_comb begin
        sum = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        if (sum[ACC_W] && SAT) begin
            res = {ACC_W{1'b1}};
        end else begin
            res = sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/mult_acc_8x8_stage.sv
// Packet accumulator for multiplier products: sums beats until in_last and
// presents one registered result per packet over valid/ready.
module mult_acc_8x8_stage
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [LEN_W-1:0]  out_cnt,
    output logic              out_ovf
);

    acc_state_e         state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [LEN_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               out_valid_r;

    logic               accept_s;
    logic [ACC_W-1:0]   base_s;
    logic [ACC_W:0]     sum_s;
    logic [ACC_W-1:0]   add_res_s;
    logic [LEN_W-1:0]   cnt_next_s;
    logic               ovf_next_s;

    sat_add_acc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_add (
        .base   (base_s),
        .prod   (in_prod),
        .sum    (sum_s),
        .res    (add_res_s)
    );

    // Next-beat values; a beat arriving in IDLE starts a fresh packet.
    always_comb begin
        accept_s = in_valid && (state_r != HOLD) && !clear;
        if (state_r == ACC) begin
            base_s     = acc_r;
            ovf_next_s = ovf_r | sum_s[ACC_W];
            if (cnt_r == {LEN_W{1'b1}}) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + {{(LEN_W - 1){1'b0}}, 1'b1};
            end
        end else begin
            base_s     = {ACC_W{1'b0}};
            ovf_next_s = sum_s[ACC_W];
            cnt_next_s = {{(LEN_W - 1){1'b0}}, 1'b1};
        end
    end

    // Packet FSM and result registers; clear overrides any beat or handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACC: begin
                    if (accept_s) begin
                        acc_r <= add_res_s;
                        cnt_r <= cnt_next_s;
                        ovf_r <= ovf_next_s;
                        if (in_last) begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ACC;
                            out_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= HOLD;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r != HOLD);
    assign out_valid = out_valid_r;
    assign out_acc   = acc_r;
    assign out_cnt   = cnt_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_mult_acc_8x8_stage.sv
// Directed bench: a saturating and a wrapping instance share one stimulus
// stream and are checked against hand-computed packet results.
module tb_mult_acc_8x8_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [23:0] s_out_acc;
    logic [7:0]  s_out_cnt;
    logic        w_in_ready, w_out_valid, w_out_ovf;
    logic [23:0] w_out_acc;
    logic [7:0]  w_out_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_acc_8x8_stage #(.PROD_W(16), .ACC_W(24), .LEN_W(8), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_acc(s_out_acc), .out_cnt(s_out_cnt), .out_ovf(s_out_ovf)
    );

    mult_acc_8x8_stage #(.PROD_W(16), .ACC_W(24), .LEN_W(8), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_acc(w_out_acc), .out_cnt(w_out_cnt), .out_ovf(w_out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sat(input string tag, input logic v, input logic [23:0] acc,
                           input logic [7:0] cnt, input logic ovf);
        chk({tag, ".sat.valid"}, {31'd0, s_out_valid}, {31'd0, v});
        chk({tag, ".sat.acc"},   {8'd0, s_out_acc},    {8'd0, acc});
        chk({tag, ".sat.cnt"},   {24'd0, s_out_cnt},   {24'd0, cnt});
        chk({tag, ".sat.ovf"},   {31'd0, s_out_ovf},   {31'd0, ovf});
    endtask

    task automatic chk_wrap(input string tag, input logic v, input logic [23:0] acc,
                            input logic [7:0] cnt, input logic ovf);
        chk({tag, ".wrap.valid"}, {31'd0, w_out_valid}, {31'd0, v});
        chk({tag, ".wrap.acc"},   {8'd0, w_out_acc},    {8'd0, acc});
        chk({tag, ".wrap.cnt"},   {24'd0, w_out_cnt},   {24'd0, cnt});
        chk({tag, ".wrap.ovf"},   {31'd0, w_out_ovf},   {31'd0, ovf});
    endtask

    task automatic chk_hs(input string tag, input logic v, input logic rdy);
        chk({tag, ".sat.valid"},  {31'd0, s_out_valid}, {31'd0, v});
        chk({tag, ".wrap.valid"}, {31'd0, w_out_valid}, {31'd0, v});
        chk({tag, ".sat.ready"},  {31'd0, s_in_ready},  {31'd0, rdy});
        chk({tag, ".wrap.ready"}, {31'd0, w_in_ready},  {31'd0, rdy});
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 16'd65025;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset held three cycles with a beat offered throughout.
        repeat (3) tick();
        chk_sat("reset", 1'b0, 24'h000000, 8'd0, 1'b0);
        chk_wrap("reset", 1'b0, 24'h000000, 8'd0, 1'b0);
        chk_hs("reset", 1'b0, 1'b1);

        // Four beats of 255*255; the beat still on the bus becomes beat 1.
        rst_n = 1'b1;
        tick();
        chk_hs("beat1", 1'b0, 1'b1);
        tick();
        tick();
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_sat("pkt4", 1'b1, 24'h03F804, 8'd4, 1'b0);
        chk_wrap("pkt4", 1'b1, 24'h03F804, 8'd4, 1'b0);
        chk_hs("pkt4", 1'b1, 1'b0);

        // Backpressure with a beat offered during HOLD.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 16'd9;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_sat("hold", 1'b1, 24'h03F804, 8'd4, 1'b0);
            chk_hs("hold", 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk_hs("handshake", 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_sat("after_hold", 1'b1, 24'h000009, 8'd1, 1'b0);
        chk_wrap("after_hold", 1'b1, 24'h000009, 8'd1, 1'b0);
        tick();
        chk_hs("after_hold_hs", 1'b0, 1'b1);

        // 300 beats of 65025 = 19507500: clamps vs wraps to 0x29A92C.
        in_valid = 1'b1;
        in_prod  = 16'd65025;
        for (int i = 0; i < 299; i++) begin
            tick();
        end
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_sat("pkt300", 1'b1, 24'hFFFFFF, 8'd255, 1'b1);
        chk_wrap("pkt300", 1'b1, 24'h29A92C, 8'd255, 1'b1);
        tick();
        chk_hs("pkt300_hs", 1'b0, 1'b1);

        // Clear mid-packet drops the concurrent beat; next packet starts fresh.
        in_valid = 1'b1;
        in_prod  = 16'd100;
        tick();
        tick();
        clear   = 1'b1;
        in_prod = 16'd50;
        tick();
        clear = 1'b0;
        chk_hs("clear_acc", 1'b0, 1'b1);
        in_prod   = 16'd7;
        in_last   = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_sat("post_clear", 1'b1, 24'h000007, 8'd1, 1'b0);
        chk_wrap("post_clear", 1'b1, 24'h000007, 8'd1, 1'b0);
        tick();
        chk_hs("held", 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_hs("clear_hold", 1'b0, 1'b1);
        out_ready = 1'b1;

        // Single zero-valued beat with last.
        in_valid = 1'b1;
        in_prod  = 16'd0;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_sat("single0", 1'b1, 24'h000000, 8'd1, 1'b0);
        chk_wrap("single0", 1'b1, 24'h000000, 8'd1, 1'b0);
        tick();
        chk_hs("single0_hs", 1'b0, 1'b1);

        // Asynchronous reset while a result is held.
        in_valid  = 1'b1;
        in_prod   = 16'd3;
        in_last   = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_hs("pre_rst", 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_sat("async_rst", 1'b0, 24'h000000, 8'd0, 1'b0);
        chk_hs("async_rst", 1'b0, 1'b1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
